// File: rtl/avmm_pattern_master.sv
// rtl/avmm_pattern_master.sv - AVMM master that writes a seeded pattern over a word window and reads it back with pipelined checking
module avmm_pattern_master #(
    parameter int ADDR_W  = 20,
    parameter int DATA_W  = 32,
    parameter int CNT_W   = 16,
    parameter int MAX_OUT = 8,
    parameter int ERR_W   = 16
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    input  logic [1:0]          mode,
    input  logic [ADDR_W-1:0]   base_addr,
    input  logic [CNT_W-1:0]    num_words,
    input  logic [DATA_W-1:0]   seed,
    output logic                busy,
    output logic                done,
    output logic                pass,
    output logic [ERR_W-1:0]    err_count,
    output logic [ADDR_W-1:0]   first_err_addr,
    input  logic                avmm_master_waitrequest,
    input  logic [DATA_W-1:0]   avmm_master_readdata,
    input  logic                avmm_master_readdatavalid,
    output logic [ADDR_W-1:0]   avmm_master_address,
    output logic [DATA_W-1:0]   avmm_master_writedata,
    output logic                avmm_master_write,
    output logic                avmm_master_read,
    output logic [DATA_W/8-1:0] avmm_master_byteenable
);
    localparam int BYTES = DATA_W / 8;
    localparam int OUT_W = $clog2(MAX_OUT + 1);

    typedef enum logic [2:0] {IDLE, WR, RD, DRAIN, FIN} state_t;

    state_t             state;
    logic               read_after_write;
    logic [CNT_W-1:0]   num_r;
    logic [CNT_W-1:0]   i;
    logic [CNT_W-1:0]   r;
    logic [ADDR_W-1:0]  base_r;
    logic [ADDR_W-1:0]  rsp_addr;
    logic [DATA_W-1:0]  rsp_pat;
    logic [OUT_W-1:0]   outstanding;

    logic               wr_acc;
    logic               rd_acc;
    logic               rsp_ok;
    logic [OUT_W-1:0]   out_next;

    assign avmm_master_byteenable = '1;

    // Responses only count while a read phase is live and something is owed,
    // so stale readdatavalid left over from an abandoned run is dropped.
    always_comb begin
        wr_acc   = avmm_master_write && !avmm_master_waitrequest;
        rd_acc   = avmm_master_read && !avmm_master_waitrequest;
        rsp_ok   = avmm_master_readdatavalid && (outstanding != '0) &&
                   (state == RD || state == DRAIN);
        out_next = outstanding + OUT_W'(rd_acc) - OUT_W'(rsp_ok);
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state                 <= IDLE;
            read_after_write      <= 1'b0;
            num_r                 <= '0;
            i                     <= '0;
            r                     <= '0;
            base_r                <= '0;
            rsp_addr              <= '0;
            rsp_pat               <= '0;
            outstanding           <= '0;
            busy                  <= 1'b0;
            done                  <= 1'b0;
            pass                  <= 1'b0;
            err_count             <= '0;
            first_err_addr        <= '0;
            avmm_master_address   <= '0;
            avmm_master_writedata <= '0;
            avmm_master_write     <= 1'b0;
            avmm_master_read      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy                  <= 1'b1;
                        done                  <= 1'b0;
                        pass                  <= 1'b0;
                        err_count             <= '0;
                        first_err_addr        <= '0;
                        num_r                 <= num_words;
                        base_r                <= base_addr;
                        read_after_write      <= (mode != 2'd0);
                        i                     <= '0;
                        r                     <= '0;
                        outstanding           <= '0;
                        rsp_addr              <= base_addr;
                        rsp_pat               <= seed;
                        avmm_master_address   <= base_addr;
                        avmm_master_writedata <= seed;
                        if (num_words == '0) begin
                            state <= FIN;
                        end else if (mode == 2'd1) begin
                            state            <= RD;
                            avmm_master_read <= 1'b1;
                        end else begin
                            state             <= WR;
                            avmm_master_write <= 1'b1;
                        end
                    end
                end
                WR: begin
                    if (wr_acc) begin
                        if (i == num_r - 1'b1) begin
                            avmm_master_write <= 1'b0;
                            i                 <= '0;
                            if (read_after_write) begin
                                state               <= RD;
                                avmm_master_read    <= 1'b1;
                                avmm_master_address <= base_r;
                            end else begin
                                state <= FIN;
                            end
                        end else begin
                            i                     <= i + 1'b1;
                            avmm_master_address   <= avmm_master_address + ADDR_W'(BYTES);
                            avmm_master_writedata <= avmm_master_writedata + 1'b1;
                        end
                    end
                end
                RD: begin
                    outstanding <= out_next;
                    if (rd_acc && i == num_r - 1'b1) begin
                        avmm_master_read <= 1'b0;
                        state            <= DRAIN;
                    end else begin
                        if (rd_acc) begin
                            i                   <= i + 1'b1;
                            avmm_master_address <= avmm_master_address + ADDR_W'(BYTES);
                        end
                        avmm_master_read <= (out_next < OUT_W'(MAX_OUT));
                    end
                end
                DRAIN: begin
                    outstanding <= out_next;
                    if (outstanding == '0 && r == num_r) begin
                        state <= FIN;
                    end
                end
                FIN: begin
                    busy  <= 1'b0;
                    done  <= 1'b1;
                    pass  <= (err_count == '0);
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase

            if (rsp_ok) begin
                r        <= r + 1'b1;
                rsp_addr <= rsp_addr + ADDR_W'(BYTES);
                rsp_pat  <= rsp_pat + 1'b1;
                if (avmm_master_readdata != rsp_pat) begin
                    if (err_count != '1) begin
                        err_count <= err_count + 1'b1;
                    end
                    if (err_count == '0) begin
                        first_err_addr <= rsp_addr;
                    end
                end
            end
        end
    end
endmodule

// File: tb/tb_avmm_pattern_master.sv
// tb/tb_avmm_pattern_master.sv - scoreboard bench for avmm_pattern_master with a latency-configurable memory model
module tb_avmm_pattern_master;
    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic [1:0]  mode = 2'd0;
    logic [19:0] base_addr = '0;
    logic [15:0] num_words = '0;
    logic [31:0] seed = '0;
    logic        busy, done, pass;
    logic [15:0] err_count;
    logic [19:0] first_err_addr;
    logic        waitrequest = 1'b0;
    logic [31:0] readdata = '0;
    logic        readdatavalid = 1'b0;
    logic [19:0] address;
    logic [31:0] writedata;
    logic        write, read;
    logic [3:0]  byteenable;

    always #5 clk = ~clk;

    avmm_pattern_master #(
        .ADDR_W(20), .DATA_W(32), .CNT_W(16), .MAX_OUT(8), .ERR_W(16)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .base_addr(base_addr),
        .num_words(num_words), .seed(seed), .busy(busy), .done(done), .pass(pass),
        .err_count(err_count), .first_err_addr(first_err_addr),
        .avmm_master_waitrequest(waitrequest), .avmm_master_readdata(readdata),
        .avmm_master_readdatavalid(readdatavalid), .avmm_master_address(address),
        .avmm_master_writedata(writedata), .avmm_master_write(write),
        .avmm_master_read(read), .avmm_master_byteenable(byteenable)
    );

    int n_checks = 0;
    int n_fail = 0;
    int cyc = 0;

    typedef struct {
        int          due;
        logic [31:0] d;
    } rsp_t;

    logic [31:0] mem [logic [19:0]];
    rsp_t        pend[$];
    logic [19:0] exp_wr_a[$];
    logic [31:0] exp_wr_d[$];
    logic [19:0] exp_rd_a[$];

    bit          wr_rand = 0;
    int          lat = 2;
    bit          corrupt_en = 0;
    logic [19:0] corrupt_addr = '0;
    int          outst = 0;
    int          max_out_seen = 0;
    int          wr_cnt = 0;
    int          rd_cnt = 0;
    int          stall_cnt = 0;
    int          first_wr_cyc = -1;
    int          last_wr_cyc = -1;
    int          start_cyc = 0;
    bit          prev_stall = 0;
    logic        prev_w, prev_r;
    logic [19:0] prev_a;
    logic [31:0] prev_d;

    // Memory slave and request scoreboard; acts on the falling edge so its
    // waitrequest/readdatavalid apply to the following rising edge.
    always @(negedge clk) begin
        logic        w;
        logic [31:0] rd;
        logic [19:0] ea;
        logic [31:0] ed;
        cyc++;
        if (!rst) begin
            outst      = 0;
            prev_stall = 0;
        end
        if (rst && prev_stall) begin
            n_checks++;
            if (write !== prev_w || read !== prev_r || address !== prev_a || writedata !== prev_d) begin
                n_fail++;
                $display("FAIL stall_hold cyc=%0d got w=%b r=%b a=%h d=%h want w=%b r=%b a=%h d=%h",
                         cyc, write, read, address, writedata, prev_w, prev_r, prev_a, prev_d);
            end
        end
        w = wr_rand ? 1'($urandom_range(0, 1)) : 1'b0;
        waitrequest = w;
        if (rst && write && read) begin
            n_checks++;
            n_fail++;
            $display("FAIL wr_rd_exclusive cyc=%0d got write=1 read=1 want not both", cyc);
        end
        if (rst && write && !w) begin
            wr_cnt++;
            if (first_wr_cyc < 0) first_wr_cyc = cyc;
            last_wr_cyc = cyc;
            mem[address] = writedata;
            n_checks++;
            if (exp_wr_a.size() == 0) begin
                n_fail++;
                $display("FAIL write_unexpected got a=%h d=%h want no write", address, writedata);
            end else begin
                ea = exp_wr_a.pop_front();
                ed = exp_wr_d.pop_front();
                if (address !== ea || writedata !== ed) begin
                    n_fail++;
                    $display("FAIL write_txn got a=%h d=%h want a=%h d=%h", address, writedata, ea, ed);
                end
            end
        end
        if (rst && read && !w) begin
            rd_cnt++;
            n_checks++;
            if (exp_rd_a.size() == 0) begin
                n_fail++;
                $display("FAIL read_unexpected got a=%h want no read", address);
            end else begin
                ea = exp_rd_a.pop_front();
                if (address !== ea) begin
                    n_fail++;
                    $display("FAIL read_addr got a=%h want a=%h", address, ea);
                end
            end
            rd = mem.exists(address) ? mem[address] : 32'hDEAD_BEEF;
            if (corrupt_en && address == corrupt_addr) rd = 32'h0000_00FF;
            pend.push_back('{cyc + lat, rd});
            outst++;
            if (outst > max_out_seen) max_out_seen = outst;
        end
        if (rst && (write || read) && w) stall_cnt++;
        prev_stall = rst && (write || read) && w;
        prev_w = write;
        prev_r = read;
        prev_a = address;
        prev_d = writedata;
        if (pend.size() > 0 && pend[0].due <= cyc) begin
            readdatavalid = 1'b1;
            readdata      = pend[0].d;
            pend.delete(0);
            if (outst > 0) outst--;
        end else begin
            readdatavalid = 1'b0;
            readdata      = '0;
        end
    end

    task automatic kick(input logic [1:0] m, input logic [19:0] b, input logic [15:0] n,
                        input logic [31:0] s);
        for (int k = 0; k < int'(n); k++) begin
            if (m != 2'd1) begin
                exp_wr_a.push_back(b + 20'(k * 4));
                exp_wr_d.push_back(s + 32'(k));
            end
            if (m != 2'd0) exp_rd_a.push_back(b + 20'(k * 4));
        end
        @(negedge clk); #1;
        mode = m; base_addr = b; num_words = n; seed = s;
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_done(input int budget, output bit ok);
        ok = 0;
        for (int k = 0; k < budget; k++) begin
            if (done) begin
                ok = 1;
                break;
            end
            @(negedge clk); #1;
        end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        #1;
        n_checks++;
        if ({busy, done, pass, write, read, err_count, first_err_addr, address, writedata} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs got busy=%b done=%b pass=%b w=%b r=%b err=%h fea=%h a=%h d=%h want all 0",
                     busy, done, pass, write, read, err_count, first_err_addr, address, writedata);
        end
        n_checks++;
        if (byteenable !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_byteenable got %h want f", byteenable);
        end
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_after_reset got busy=%b done=%b want 0 0", busy, done);
        end
    endtask

    task automatic test_basic;
        bit ok;
        int wc, rc;
        lat = 2; corrupt_en = 0; first_wr_cyc = -1;
        wc = wr_cnt; rc = rd_cnt;
        kick(2'd2, 20'h00100, 16'd4, 32'h0000_00A0);
        wait_done(100, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL basic_timeout got done=0 want done=1"); end
        n_checks++;
        if (first_wr_cyc != start_cyc + 1) begin
            n_fail++;
            $display("FAIL basic_first_req_latency got cyc=%0d want %0d", first_wr_cyc, start_cyc + 1);
        end
        n_checks++;
        if (last_wr_cyc - first_wr_cyc != 3) begin
            n_fail++;
            $display("FAIL basic_b2b_writes got span=%0d want 3", last_wr_cyc - first_wr_cyc);
        end
        n_checks++;
        if (wr_cnt - wc != 4 || rd_cnt - rc != 4) begin
            n_fail++;
            $display("FAIL basic_counts got wr=%0d rd=%0d want 4 4", wr_cnt - wc, rd_cnt - rc);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 16'd0 || first_err_addr !== 20'd0) begin
            n_fail++;
            $display("FAIL basic_result got pass=%b err=%0d fea=%h want 1 0 0", pass, err_count, first_err_addr);
        end
    endtask

    task automatic test_corrupt;
        bit ok;
        corrupt_en = 1; corrupt_addr = 20'h00108; lat = 2;
        kick(2'd2, 20'h00100, 16'd4, 32'h0000_00A0);
        wait_done(100, ok);
        corrupt_en = 0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL corrupt_timeout got done=0 want done=1"); end
        n_checks++;
        if (err_count !== 16'd1 || first_err_addr !== 20'h00108 || pass !== 1'b0) begin
            n_fail++;
            $display("FAIL corrupt_result got err=%0d fea=%h pass=%b want 1 00108 0",
                     err_count, first_err_addr, pass);
        end
    endtask

    task automatic test_max_outstanding;
        bit ok;
        int wc, rc;
        for (int k = 0; k < 20; k++) mem[20'h01000 + 20'(k * 4)] = 32'h5555_0000 + 32'(k);
        lat = 12; max_out_seen = 0;
        wc = wr_cnt; rc = rd_cnt;
        kick(2'd1, 20'h01000, 16'd20, 32'h5555_0000);
        wait_done(400, ok);
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL maxout_timeout got done=0 want done=1"); end
        n_checks++;
        if (max_out_seen != 8) begin
            n_fail++;
            $display("FAIL maxout_limit got peak=%0d want 8", max_out_seen);
        end
        n_checks++;
        if (rd_cnt - rc != 20 || wr_cnt - wc != 0) begin
            n_fail++;
            $display("FAIL maxout_counts got rd=%0d wr=%0d want 20 0", rd_cnt - rc, wr_cnt - wc);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 16'd0) begin
            n_fail++;
            $display("FAIL maxout_result got pass=%b err=%0d want 1 0", pass, err_count);
        end
    endtask

    task automatic test_random_wait;
        bit ok;
        int wc, rc;
        wr_rand = 1; lat = 3; stall_cnt = 0;
        wc = wr_cnt; rc = rd_cnt;
        kick(2'd2, 20'h02000, 16'd16, 32'h1234_5678);
        repeat (4) @(negedge clk);
        #1;
        mode = 2'd0; num_words = 16'd3; base_addr = 20'h0; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        wait_done(600, ok);
        wr_rand = 0;
        n_checks++;
        if (!ok) begin n_fail++; $display("FAIL randwait_timeout got done=0 want done=1"); end
        n_checks++;
        if (wr_cnt - wc != 16 || rd_cnt - rc != 16) begin
            n_fail++;
            $display("FAIL randwait_counts got wr=%0d rd=%0d want 16 16", wr_cnt - wc, rd_cnt - rc);
        end
        n_checks++;
        if (stall_cnt == 0) begin
            n_fail++;
            $display("FAIL randwait_stalls got %0d stalled cycles want >0", stall_cnt);
        end
        n_checks++;
        if (pass !== 1'b1 || err_count !== 16'd0 || exp_wr_a.size() != 0 || exp_rd_a.size() != 0) begin
            n_fail++;
            $display("FAIL randwait_result got pass=%b err=%0d leftover wr=%0d rd=%0d want 1 0 0 0",
                     pass, err_count, exp_wr_a.size(), exp_rd_a.size());
        end
    endtask

    task automatic test_zero_words;
        int wc, rc;
        wc = wr_cnt; rc = rd_cnt;
        kick(2'd2, 20'h00400, 16'd0, 32'h0);
        n_checks++;
        if (busy !== 1'b1 || done !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_busy got busy=%b done=%b want 1 0", busy, done);
        end
        mode = 2'd0; num_words = 16'd5; start = 1'b1;
        @(negedge clk); #1;
        start = 1'b0;
        n_checks++;
        if (done !== 1'b1 || pass !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_done got done=%b pass=%b busy=%b want 1 1 0", done, pass, busy);
        end
        repeat (6) @(negedge clk);
        #1;
        n_checks++;
        if (wr_cnt != wc || rd_cnt != rc || done !== 1'b1 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL zero_quiet got wr=%0d rd=%0d done=%b busy=%b want 0 0 1 0",
                     wr_cnt - wc, rd_cnt - rc, done, busy);
        end
    endtask

    task automatic test_reset_mid_read;
        bit ok;
        int k;
        lat = 12;
        kick(2'd1, 20'h04000, 16'd8, 32'h0);
        k = 0;
        while (outst < 3 && k < 50) begin
            @(negedge clk); #1;
            k++;
        end
        n_checks++;
        if (outst != 3) begin
            n_fail++;
            $display("FAIL midrd_setup got outstanding=%0d want 3", outst);
        end
        rst = 1'b0;
        #1;
        n_checks++;
        if ({busy, done, pass, write, read, err_count, first_err_addr, address, writedata} !== '0) begin
            n_fail++;
            $display("FAIL midrd_reset_outputs got busy=%b w=%b r=%b err=%h a=%h want all 0",
                     busy, write, read, err_count, address);
        end
        exp_rd_a.delete();
        exp_wr_a.delete();
        exp_wr_d.delete();
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b1;
        k = 0;
        while (pend.size() > 0 && k < 40) begin
            @(negedge clk); #1;
            k++;
        end
        repeat (2) @(negedge clk);
        #1;
        n_checks++;
        if (err_count !== 16'd0 || busy !== 1'b0 || done !== 1'b0 || pend.size() != 0) begin
            n_fail++;
            $display("FAIL midrd_stale got err=%0d busy=%b done=%b pending=%0d want 0 0 0 0",
                     err_count, busy, done, pend.size());
        end
        lat = 2;
        kick(2'd2, 20'h03000, 16'd5, 32'h0000_0007);
        wait_done(100, ok);
        n_checks++;
        if (!ok || pass !== 1'b1 || err_count !== 16'd0 || exp_wr_a.size() != 0 || exp_rd_a.size() != 0) begin
            n_fail++;
            $display("FAIL midrd_rerun got done=%b pass=%b err=%0d leftover=%0d want 1 1 0 0",
                     done, pass, err_count, exp_wr_a.size() + exp_rd_a.size());
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_corrupt;
        test_max_outstanding;
        test_random_wait;
        test_zero_words;
        test_reset_mid_read;
        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule
